// File: rtl/stereo_pixel_fetcher.sv
// Stereo frame-scan read engine: raster-walks both frame-buffer BRAMs with a shared address and
// streams re-aligned (left, right, h, v) tuples over valid/ready. Optional macro: FETCH_OVERRUN_FLAG_EN.
module stereo_pixel_fetcher #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int ADDR_W      = 17,
  parameter int PIX_W       = 8,
  parameter int RAM_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      new_frame_in,
  output logic [ADDR_W-1:0]         ram_addr_out,
  output logic                      ram_en_out,
  input  logic [PIX_W-1:0]          left_data_in,
  input  logic [PIX_W-1:0]          right_data_in,
  output logic [PIX_W-1:0]          pix_left_out,
  output logic [PIX_W-1:0]          pix_right_out,
  output logic [$clog2(WIDTH)-1:0]  hcount_out,
  output logic [$clog2(HEIGHT)-1:0] vcount_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      busy_out,
  output logic                      frame_done_out
`ifdef FETCH_OVERRUN_FLAG_EN
  ,
  output logic                      overrun_out
`endif
);

  localparam int DEPTH = RAM_LATENCY + 2;
  localparam int H_W   = $clog2(WIDTH);
  localparam int V_W   = $clog2(HEIGHT);
  localparam int P_W   = $clog2(DEPTH);
  localparam int C_W   = $clog2(DEPTH + 1);

  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [H_W-1:0]    H_LAST  = H_W'(WIDTH - 1);
  localparam logic [P_W-1:0]    P_LAST  = P_W'(DEPTH - 1);
  localparam logic [C_W-1:0]    DEPTH_C = C_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic [PIX_W-1:0] left;
    logic [PIX_W-1:0] right;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
  } entry_t;

  state_t           state;
  logic [H_W-1:0]   scan_h;
  logic [V_W-1:0]   scan_v;
  // Reads issued but not yet handed downstream: in-flight pipe plus FIFO occupancy.
  logic [C_W-1:0]   used;
  logic [C_W-1:0]   used_next;

  logic             pipe_vld [RAM_LATENCY];
  logic [H_W-1:0]   pipe_h   [RAM_LATENCY];
  logic [V_W-1:0]   pipe_row [RAM_LATENCY];

  entry_t           fifo_mem [DEPTH];
  logic [P_W-1:0]   wr_ptr;
  logic [P_W-1:0]   rd_ptr;
  logic [C_W-1:0]   fifo_cnt;
  entry_t           head;

  logic             push;
  logic             pop;
  logic             start;
  logic             last_issue;
  logic             scan_next;

  function automatic logic [P_W-1:0] ptr_inc(input logic [P_W-1:0] p);
    return (p == P_LAST) ? '0 : p + 1'b1;
  endfunction

  assign head          = fifo_mem[rd_ptr];
  assign pix_left_out  = head.left;
  assign pix_right_out = head.right;
  assign hcount_out    = head.h;
  assign vcount_out    = head.v;
  assign valid_out     = (fifo_cnt != '0);
  assign busy_out      = (state != IDLE);

  always_comb begin
    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    pop        = valid_out & ready_in;
    push       = pipe_vld[RAM_LATENCY-1];
    start      = (state == IDLE) & new_frame_in;
    last_issue = ram_en_out & (ram_addr_out == A_LAST);
    used_next  = used + {{(C_W-1){1'b0}}, ram_en_out} - {{(C_W-1){1'b0}}, pop};
    scan_next  = start | ((state == SCAN) & ~last_issue);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      ram_en_out     <= 1'b0;
      ram_addr_out   <= '0;
      scan_h         <= '0;
      scan_v         <= '0;
      used           <= '0;
      frame_done_out <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_h[i]   <= '0;
        pipe_row[i] <= '0;
      end
      // NOTE: the FIFO storage is cleared too so the head reads zero after reset, not stale pixels.
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      // NOTE: all state uses <= so every register samples pre-edge values regardless of statement order.
      ram_en_out     <= scan_next & (used_next < DEPTH_C);
      used           <= used_next;
      frame_done_out <= (state == DRAIN) & (used_next == '0) & ~frame_done_out;

      case (state)
        IDLE:    if (new_frame_in) state <= SCAN;
        SCAN:    if (last_issue) state <= DRAIN;
        DRAIN:   if (frame_done_out) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Incremental raster walk; the last issue rewinds so the next frame starts clean.
      if (start || last_issue) begin
        ram_addr_out <= '0;
        scan_h       <= '0;
        scan_v       <= '0;
      end else if (ram_en_out) begin
        ram_addr_out <= ram_addr_out + 1'b1;
        if (scan_h == H_LAST) begin
          scan_h <= '0;
          scan_v <= scan_v + 1'b1;
        end else begin
          scan_h <= scan_h + 1'b1;
        end
      end

      pipe_vld[0] <= ram_en_out;
      pipe_h[0]   <= scan_h;
      pipe_row[0] <= scan_v;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_h[i]   <= pipe_h[i-1];
        pipe_row[i] <= pipe_row[i-1];
      end

      if (push) begin
        fifo_mem[wr_ptr] <= '{left:  left_data_in,
                              right: right_data_in,
                              h:     pipe_h[RAM_LATENCY-1],
                              v:     pipe_row[RAM_LATENCY-1]};
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

`ifdef FETCH_OVERRUN_FLAG_EN
  always_ff @(posedge clk_in) begin
    if (rst_in || start)              overrun_out <= 1'b0;
    else if (new_frame_in && busy_out) overrun_out <= 1'b1;
  end
`endif

endmodule
